// File: rtl/register_file_rename.sv
// register_file_rename
//   Architectural register file with per-register rename tags. Sits beside the
//   dispatcher (operand reads, destination renames) and behind the ROB commit
//   port (retired values, tag clears). Rollback flushes every tag so all
//   registers read their architectural values again.
//
//   Interface contract: there is no back-pressure. Every rename, commit or
//   rollback presented while rdy_in=1 is accepted on that rising edge; with
//   rdy_in=0 all state holds and reads show stored state with no bypass.
//
// Ports
//   clk_in, rst_in (async, active-high), rdy_in (global enable)
//   rs1/rs2_from_dispatcher -> V1/Q1, V2/Q2_to_dispatcher (combinational reads)
//   rename_enable/rd/rob_id_from_dispatcher  destination rename request
//   commit_flag, rd/V/Q_from_rob              ROB commit
//   rollback_flag                             flush all tags
//   busy_count_out                            registered count of nonzero tags
module register_file_rename #(
    parameter int REG_NUM  = 32,
    parameter int REG_W    = 5,
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 6
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic [REG_W-1:0]    rs1_from_dispatcher,
    input  logic [REG_W-1:0]    rs2_from_dispatcher,
    output logic [DATA_W-1:0]   V1_to_dispatcher,
    output logic [ROB_ID_W-1:0] Q1_to_dispatcher,
    output logic [DATA_W-1:0]   V2_to_dispatcher,
    output logic [ROB_ID_W-1:0] Q2_to_dispatcher,
    input  logic                rename_enable_from_dispatcher,
    input  logic [REG_W-1:0]    rd_from_dispatcher,
    input  logic [ROB_ID_W-1:0] rob_id_from_dispatcher,
    input  logic                commit_flag,
    input  logic [REG_W-1:0]    rd_from_rob,
    input  logic [DATA_W-1:0]   V_from_rob,
    input  logic [ROB_ID_W-1:0] Q_from_rob,
    input  logic                rollback_flag,
    output logic [5:0]          busy_count_out
);

    logic [DATA_W-1:0]   value_q  [REG_NUM];
    logic [ROB_ID_W-1:0] tag_q    [REG_NUM];
    logic [ROB_ID_W-1:0] tag_next [REG_NUM];
    logic [5:0]          busy_next;

    logic commit_wr;
    logic rename_wr;

    // x0 is never written, so its value and tag stay at their reset zero.
    assign commit_wr = commit_flag && (rd_from_rob != '0);
    assign rename_wr = rename_enable_from_dispatcher && (rd_from_dispatcher != '0)
                       && !rollback_flag;

    // Next-state tags. The rename is applied after the commit clear so a
    // same-register rename wins over the clear.
    always_comb begin
        tag_next = tag_q;
        if (commit_wr && (tag_q[rd_from_rob] == Q_from_rob)) begin
            tag_next[rd_from_rob] = '0;
        end
        if (rollback_flag) begin
            for (int i = 0; i < REG_NUM; i++) begin
                tag_next[i] = '0;
            end
        end else if (rename_wr) begin
            tag_next[rd_from_dispatcher] = rob_id_from_dispatcher;
        end
    end

    always_comb begin
        busy_next = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (tag_next[i] != '0) begin
                busy_next = busy_next + 6'd1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_count_out <= '0;
        end else if (rdy_in) begin
            // Stale commits still retire their value; only the tag clear is
            // conditional on the ROB id matching.
            if (commit_wr) begin
                value_q[rd_from_rob] <= V_from_rob;
            end
            for (int i = 0; i < REG_NUM; i++) begin
                tag_q[i] <= tag_next[i];
            end
            busy_count_out <= busy_next;
        end
    end

    // Operand read: {value, tag}. A commit retiring the current producer is
    // forwarded so the dispatcher sees a ready operand in the same cycle.
    // Same-cycle renames are deliberately invisible (add x1,x1,x2).
    function automatic logic [DATA_W+ROB_ID_W-1:0] read_src(input logic [REG_W-1:0] idx);
        logic [DATA_W+ROB_ID_W-1:0] r;
        if (idx == '0) begin
            r = '0;
        end else if (rdy_in && commit_flag && (rd_from_rob == idx)
                     && (tag_q[idx] != '0) && (tag_q[idx] == Q_from_rob)) begin
            r = {V_from_rob, {ROB_ID_W{1'b0}}};
        end else begin
            r = {value_q[idx], tag_q[idx]};
        end
        return r;
    endfunction

    always_comb begin
        {V1_to_dispatcher, Q1_to_dispatcher} = read_src(rs1_from_dispatcher);
        {V2_to_dispatcher, Q2_to_dispatcher} = read_src(rs2_from_dispatcher);
    end

endmodule
